i2s_mic_receiver: RTL and testbench
===================================

Name: i2s_mic_receiver

Overview:
- Receive side of the sound-box I2S path: deserialises external microphone I2S (mic_bclk, mic_lrck, mic_data) into 16-bit stereo frames in the clk27 domain.
- Frames go into a small FIFO with a valid/ready output. The SPI microphone path and the monitor-link sender drain that FIFO.
- This block is the counterpart of the I2S sender that drives audio_bclk/lrck/data.

Parameters:
- SAMPLE_W, 16, bits kept per channel, MSB-first.
- FIFO_DEPTH, 4, frame FIFO entries; power of two, at least 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- clk27  in  1  FPGA system clock; all logic runs on its rising edge.
- hw_reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; low forces resync and prevents pushes.
- mic_bclk  in  1  I2S bit clock (async); at most clk27/6.
- mic_lrck  in  1  I2S word select (async); 0 = left, 1 = right.
- mic_data  in  1  I2S serial data (async).
- sample_ready  in  1  consumer accepts the head frame.
- sample_valid  out  1  FIFO not empty.
- sample_left  out  SAMPLE_W  head-frame left channel.
- sample_right  out  SAMPLE_W  head-frame right channel.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- short_word  out  1  sticky: a word had fewer than SAMPLE_W bits.
- clear_flags  in  1  synchronous clear of overflow and short_word.

Behaviour:
- Synchronisation:
  - mic_bclk, mic_lrck and mic_data each pass through a 2-FF synchroniser.
  - A bclk rising-edge strobe (be) is a one-cycle pulse when synced bclk goes 0 -> 1.
  - lrck and data are used only on be cycles.
- Sampling registers:
  - On each be: lr_d <= lrck; lr_dd <= lr_d.
  - The data bit sampled on a be belongs to channel lr_d, the value before the update (standard I2S one-bit delay).
  - Word boundary: when lr_d != lr_dd on a be, the current bit is the MSB of the new word.
- FSM, states SYNC, CAPTURE:
  - SYNC (reset state, and whenever enable = 0): no shifting. Move to CAPTURE on the first be that detects an lr_dd = 1 -> lr_d = 0 boundary, i.e. the start of a left word. That bit is the left MSB.
  - CAPTURE:
    - Shift bits into the current channel register while bit_cnt < SAMPLE_W; bit_cnt saturates at SAMPLE_W.
    - Bits beyond SAMPLE_W are ignored.
    - At each word boundary, finish the previous word. If bit_cnt < SAMPLE_W, left-align the word, zero-fill the LSBs and set short_word.
    - Left word completes at a 0 -> 1 boundary.
    - Right word completes at a 1 -> 0 boundary and generates push of {left, right}.
- FIFO:
  - Push is registered. It writes memory in the cycle after the completing be.
  - sample_valid rises the cycle after the write (push-to-valid latency 2 clk27 cycles from be).
  - Pop when sample_valid & sample_ready. Outputs show the new head the next cycle.
  - Push while full and no pop in the same cycle: frame dropped, overflow <= 1, FIFO unchanged.
  - Push and pop in the same cycle while full: both take effect, count unchanged, overflow not set.
  - Push and pop in the same cycle while empty: the push is stored and sample_valid is 1 next cycle.
  - Pointers wrap modulo FIFO_DEPTH; count is PTR_W+1 bits.
- Flags:
  - overflow and short_word are sticky until clear_flags.
  - clear_flags in the same cycle as a set event: the set wins.
- enable falling mid-word: the partial frame is discarded, the FSM goes to SYNC, and FIFO contents stay available.
- Reset (asynchronous, any time):
  - State SYNC; bit_cnt, shift registers, lr_d and lr_dd cleared; synchronisers cleared to 0.
  - FIFO empty; sample_valid = 0, sample_left = sample_right = 0, overflow = 0, short_word = 0.
  - A frame in flight is lost.

Test Plan:
- Reset, enable = 1, send frames L = 0x8001 / R = 0x7FFE with 32 bclk per frame at clk27/8 → first partial frame ignored; sample_valid rises 2 cycles after the right-LSB-completing be; outputs 0x8001 / 0x7FFE; no flags.
- 5 frames (0x0001..0x0005 left, inverted right) with sample_ready = 0 → first 4 held in order, overflow = 1; draining with ready = 1 yields 0x0001..0x0004, then sample_valid = 0.
- FIFO full with sample_ready = 1 exactly on the push cycle → no overflow; 4 entries remain; order preserved.
- 24-bit words 0xABCDEF / 0x123456 → outputs 0xABCD / 0x1234, short_word = 0.
- 12-bit words 0xABC / 0x123 → outputs 0xABC0 / 0x1230, short_word = 1; clear_flags pulse → 0.
- enable low mid-right-word, then high → no push for the interrupted frame; capture resumes at the next left-word start. hw_reset asserted mid-frame → all outputs 0 immediately.

Source files
------------

// File: rtl/i2s_mic_receiver_if.sv
// Frame stream from the I2S microphone receiver to its consumers.
//   sample_valid : head frame present (producer -> consumer)
//   sample_ready : consumer accepts the head frame (consumer -> producer)
//   sample_left  : head-frame left channel
//   sample_right : head-frame right channel
// master = producer (receiver), slave = consumer.
interface i2s_mic_receiver_if #(
    parameter int SAMPLE_W = 16
);
    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_left;
    logic [SAMPLE_W-1:0] sample_right;

    modport master (
        output sample_valid,
        output sample_left,
        output sample_right,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_left,
        input  sample_right,
        output sample_ready
    );
endinterface

// File: rtl/i2s_mic_receiver.sv
// I2S microphone receiver: deserialises an asynchronous I2S stream into
// left-aligned SAMPLE_W-bit stereo frames in the clk27 domain and queues
// them in a small frame FIFO.
//   clk27       : system clock, rising edge
//   hw_reset    : asynchronous active-high reset
//   enable      : capture enable; low forces resync and stops pushes
//   mic_bclk    : I2S bit clock (async, <= clk27/6)
//   mic_lrck    : I2S word select (async), 0 = left, 1 = right
//   mic_data    : I2S serial data (async)
//   clear_flags : synchronous clear of the sticky flags
//   overflow    : sticky, a frame was dropped on a full FIFO
//   short_word  : sticky, a word had fewer than SAMPLE_W bits
//   smp         : frame stream (valid/ready, left, right)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_SYNC    | waiting for a left-word start (lrck 1 -> 0), nothing shifts
// ST_CAPTURE | shifting bits into the current word, pushing frames
module i2s_mic_receiver #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic clk27,
    input  logic hw_reset,
    input  logic enable,
    input  logic mic_bclk,
    input  logic mic_lrck,
    input  logic mic_data,
    input  logic clear_flags,
    output logic overflow,
    output logic short_word,
    i2s_mic_receiver_if.master smp
);

    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(SAMPLE_W);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_SYNC, ST_CAPTURE} state_t;

    // Synchronisers; bclk carries a third stage for edge detection.
    logic [2:0] bclk_q;
    logic [1:0] lrck_q;
    logic [1:0] data_q;
    logic       be;
    logic       lrck_s;
    logic       data_s;

    always_ff @(posedge clk27 or posedge hw_reset) begin
        if (hw_reset) begin
            bclk_q <= '0;
            lrck_q <= '0;
            data_q <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], mic_bclk};
            lrck_q <= {lrck_q[0], mic_lrck};
            data_q <= {data_q[0], mic_data};
        end
    end

    assign be     = bclk_q[1] & ~bclk_q[2];
    assign lrck_s = lrck_q[1];
    assign data_s = data_q[1];

    state_t               state_q;
    logic                 lr_prev_q;   // lr_d: channel owning the bit sampled now
    logic                 lr_prev2_q;  // lr_dd: channel of the previous bit
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [SAMPLE_W-1:0]  sh_q;
    logic [SAMPLE_W-1:0]  left_q;
    logic                 push_q;
    logic [SAMPLE_W-1:0]  push_l_q;
    logic [SAMPLE_W-1:0]  push_r_q;
    logic                 short_q;
    logic                 boundary;
    logic [SAMPLE_W-1:0]  aligned;

    assign boundary = lr_prev_q != lr_prev2_q;
    // Short words sit in the low bits of the shifter; move them to the MSBs.
    assign aligned  = sh_q << (FULL_CNT - bit_cnt_q);

    always_ff @(posedge clk27 or posedge hw_reset) begin
        if (hw_reset) begin
            state_q    <= ST_SYNC;
            lr_prev_q  <= 1'b0;
            lr_prev2_q <= 1'b0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            left_q     <= '0;
            push_q     <= 1'b0;
            push_l_q   <= '0;
            push_r_q   <= '0;
            short_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (clear_flags) begin
                short_q <= 1'b0;
            end
            if (be) begin
                lr_prev_q  <= lrck_s;
                lr_prev2_q <= lr_prev_q;
            end
            if (!enable) begin
                state_q   <= ST_SYNC;
                bit_cnt_q <= '0;
                sh_q      <= '0;
            end else if (be) begin
                case (state_q)
                    ST_SYNC: begin
                        if (lr_prev2_q && !lr_prev_q) begin
                            state_q   <= ST_CAPTURE;
                            sh_q      <= {{(SAMPLE_W-1){1'b0}}, data_s};
                            bit_cnt_q <= CNT_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        if (boundary) begin
                            if (bit_cnt_q < FULL_CNT) begin
                                short_q <= 1'b1;
                            end
                            if (!lr_prev2_q) begin
                                left_q <= aligned;
                            end else begin
                                push_q   <= 1'b1;
                                push_l_q <= left_q;
                                push_r_q <= aligned;
                            end
                            sh_q      <= {{(SAMPLE_W-1){1'b0}}, data_s};
                            bit_cnt_q <= CNT_W'(1);
                        end else if (bit_cnt_q < FULL_CNT) begin
                            sh_q      <= {sh_q[SAMPLE_W-2:0], data_s};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_SYNC;
                endcase
            end
        end
    end

    // Frame FIFO
    logic [2*SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic [PTR_W:0]        count_d;
    logic                  overflow_q;
    logic                  full;
    logic                  pop;
    logic                  do_write;
    logic                  ovf_set;

    assign full     = count_q == DEPTH_CNT;
    assign pop      = smp.sample_valid & smp.sample_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign do_write = push_q & (~full | pop);
    assign ovf_set  = push_q & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (do_write && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_write && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk27 or posedge hw_reset) begin
        if (hw_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q] <= {push_l_q, push_r_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clear_flags) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign smp.sample_valid = count_q != '0;
    assign {smp.sample_left, smp.sample_right} = mem_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign short_word = short_q;

endmodule

// File: tb/tb_i2s_mic_receiver.sv
module tb_i2s_mic_receiver;
    localparam int W = 16;

    logic clk27 = 1'b0;
    logic hw_reset, enable, mic_bclk, mic_lrck, mic_data, clear_flags;
    logic overflow, short_word;

    i2s_mic_receiver_if #(.SAMPLE_W(W)) smp ();

    i2s_mic_receiver #(.SAMPLE_W(W), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk27       (clk27),
        .hw_reset    (hw_reset),
        .enable      (enable),
        .mic_bclk    (mic_bclk),
        .mic_lrck    (mic_lrck),
        .mic_data    (mic_data),
        .clear_flags (clear_flags),
        .overflow    (overflow),
        .short_word  (short_word),
        .smp         (smp)
    );

    always #5 clk27 = ~clk27;

    int cyc = 0;
    always @(posedge clk27) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          rise_cyc = 0;
    int          mark_cyc = 0;
    bit          valid_prev = 1'b0;
    logic [31:0] fl[8];
    logic [31:0] fr[8];
    bit          prev_bit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: every accepted head frame is checked against the scoreboard.
    always @(negedge clk27) begin
        if (hw_reset) begin
            valid_prev = 1'b0;
        end else begin
            if (smp.sample_valid && !valid_prev) rise_cyc = cyc;
            valid_prev = smp.sample_valid;
            if (smp.sample_valid && smp.sample_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no frame",
                             {smp.sample_left, smp.sample_right});
                end else begin
                    chk("frame", {smp.sample_left, smp.sample_right}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk27);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"},    32'(smp.sample_valid), 32'd0);
        chk({tag, "_left"},     32'(smp.sample_left),  32'd0);
        chk({tag, "_right"},    32'(smp.sample_right), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow),         32'd0);
        chk({tag, "_short"},    32'(short_word),       32'd0);
    endtask

    // One dummy frame (lost to resync), nfr frames from fl/fr, then two
    // left slots so the last right word sees its closing boundary.
    // Each bclk half period is 4 clk27 cycles (bclk = clk27/8).
    task automatic batch(input int nbits, input int nfr, input bit measure, input bit pulse,
                         input int en_off, input int rst_at);
        bit ws_s[$];
        bit bit_s[$];
        int last;
        enable = 1'b0;
        wait_clk(2);
        enable = 1'b1;
        for (int k = 0; k < 2 * nbits; k++) begin
            ws_s.push_back(k >= nbits);
            bit_s.push_back(1'b0);
        end
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < nbits; k++) begin
                ws_s.push_back(1'b0);
                bit_s.push_back(fl[f][nbits-1-k]);
            end
            for (int k = 0; k < nbits; k++) begin
                ws_s.push_back(1'b1);
                bit_s.push_back(fr[f][nbits-1-k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            ws_s.push_back(1'b0);
            bit_s.push_back(1'b0);
        end
        last = ws_s.size() - 1;
        for (int s = 0; s <= last; s++) begin
            if (s == en_off) enable = 1'b0;
            if (en_off >= 0 && s == en_off + 3) enable = 1'b1;
            if (rst_at >= 0 && s == rst_at + 1) hw_reset = 1'b0;
            mic_lrck = ws_s[s];
            mic_data = prev_bit;   // I2S data lags word select by one bit
            prev_bit = bit_s[s];
            if (s == rst_at) begin
                hw_reset = 1'b1;
                #2;
                check_idle("mid_reset");
                exp_q.delete();
            end
            wait_clk(4);
            mic_bclk = 1'b1;
            if (s == last && measure) mark_cyc = cyc;
            if (s == last && pulse) begin
                wait_clk(3);
                smp.sample_ready = 1'b1;
                wait_clk(1);
                smp.sample_ready = 1'b0;
            end else begin
                wait_clk(4);
            end
            mic_bclk = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        smp.sample_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk27);
            if (!smp.sample_valid) break;
        end
        chk(name, 32'(smp.sample_valid), 32'd0);
        wait_clk(1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        wait_clk(1);
        clear_flags = 1'b0;
    endtask

    initial begin
        hw_reset = 1'b1; enable = 1'b0; mic_bclk = 1'b0; mic_lrck = 1'b0;
        mic_data = 1'b0; clear_flags = 1'b0; smp.sample_ready = 1'b0;
        wait_clk(3);
        hw_reset = 1'b0;
        wait_clk(2);
        check_idle("reset");
        enable = 1'b1;

        // Basic frame and push-to-valid latency
        smp.sample_ready = 1'b1;
        fl[0] = 32'h8001; fr[0] = 32'h7FFE;
        exp_q.push_back({16'h8001, 16'h7FFE});
        batch(16, 1, 1'b1, 1'b0, -1, -1);
        wait_clk(10);
        chk("t1_latency", 32'(rise_cyc - mark_cyc), 32'd4);
        chk("t1_popped", 32'(exp_q.size()), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);
        chk("t1_short", 32'(short_word), 32'd0);

        // Overflow: five frames into a four-entry FIFO
        smp.sample_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fl[i] = 32'(i + 1);
            fr[i] = 32'(16'hFFFF - 16'(i + 1));
            if (i < 4) exp_q.push_back({16'(i + 1), 16'hFFFF - 16'(i + 1)});
        end
        batch(16, 5, 1'b0, 1'b0, -1, -1);
        wait_clk(5);
        chk("t2_valid", 32'(smp.sample_valid), 32'd1);
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_head_left", 32'(smp.sample_left), 32'h0001);
        drain("t2_drained");
        chk("t2_all_popped", 32'(exp_q.size()), 32'd0);
        smp.sample_ready = 1'b0;
        pulse_clear();
        chk("t2_overflow_cleared", 32'(overflow), 32'd0);

        // Full FIFO, pop on exactly the push cycle
        for (int i = 0; i < 5; i++) begin
            fl[i] = 32'(16'h0011 + 16'(i));
            fr[i] = 32'(16'h0111 + 16'(i));
            exp_q.push_back({16'h0011 + 16'(i), 16'h0111 + 16'(i)});
        end
        batch(16, 5, 1'b0, 1'b1, -1, -1);
        wait_clk(5);
        chk("t3_overflow", 32'(overflow), 32'd0);
        chk("t3_remaining", 32'(exp_q.size()), 32'd4);
        chk("t3_head", {smp.sample_left, smp.sample_right}, {16'h0012, 16'h0112});
        drain("t3_drained");
        chk("t3_all_popped", 32'(exp_q.size()), 32'd0);

        // 24-bit words are truncated to the top 16 bits
        fl[0] = 32'hABCDEF; fr[0] = 32'h123456;
        exp_q.push_back({16'hABCD, 16'h1234});
        batch(24, 1, 1'b0, 1'b0, -1, -1);
        wait_clk(10);
        chk("t4_popped", 32'(exp_q.size()), 32'd0);
        chk("t4_short", 32'(short_word), 32'd0);

        // 12-bit words are left-aligned and flagged
        fl[0] = 32'hABC; fr[0] = 32'h123;
        exp_q.push_back({16'hABC0, 16'h1230});
        batch(12, 1, 1'b0, 1'b0, -1, -1);
        wait_clk(10);
        chk("t5_popped", 32'(exp_q.size()), 32'd0);
        chk("t5_short", 32'(short_word), 32'd1);
        pulse_clear();
        chk("t5_short_cleared", 32'(short_word), 32'd0);

        // enable low in the middle of the first real frame's right word
        smp.sample_ready = 1'b0;
        fl[0] = 32'h1111; fr[0] = 32'h2222;
        fl[1] = 32'h3333; fr[1] = 32'h4444;
        exp_q.push_back({16'h3333, 16'h4444});
        batch(16, 2, 1'b0, 1'b0, 3 * 16 + 8, -1);
        wait_clk(5);
        chk("t6_valid", 32'(smp.sample_valid), 32'd1);
        chk("t6_head", {smp.sample_left, smp.sample_right}, {16'h3333, 16'h4444});
        chk("t6_short", 32'(short_word), 32'd0);

        // hw_reset in the middle of a left word, FIFO holding a frame
        fl[0] = 32'h5555; fr[0] = 32'h6666;
        batch(16, 1, 1'b0, 1'b0, -1, 2 * 16 + 5);
        wait_clk(10);
        chk("t7_valid", 32'(smp.sample_valid), 32'd0);
        smp.sample_ready = 1'b1;
        wait_clk(5);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
